ram_fifo_ctrl: RTL and testbench

Controller that turns the 8x4 single-port RAM into a first-in-first-out queue with valid/ready handshakes on both sides. It sits directly upstream of the RAM and drives its `we`/`di`/`address` pins. It consumes the RAM's `do` and presents the data in order through a one-entry output register. Push/pop arbitration, pointer wrap, occupancy and full/empty are handled here, so the rest of the design never addresses the RAM directly.

---
 rtl/ram_fifo_pkg.sv | 15 +
 rtl/ram_fifo_ctrl_if.sv | 38 +++
 rtl/ram_fifo_ctrl_wrap_ctr.sv | 32 +++
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared constants and types for the RAM-backed FIFO controller.
//   RAM_DW / RAM_AW / RAM_DEPTH : geometry of the 8x4 single-port RAM
//   grant_t                     : kind of slot granted on the single RAM port
package ram_fifo_pkg;

  localparam int unsigned RAM_DW    = 4;
  localparam int unsigned RAM_AW    = 3;
  localparam int unsigned RAM_DEPTH = 8;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: producer/consumer handshakes, status and RAM pins of the
// FIFO controller.
//   slave  : controller view (drives in_ready, out_*, status, ram_we/di/addr)
//   master : environment view (drives in_valid/in_data, out_ready, ram_do)
interface ram_fifo_ctrl_if
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DW = RAM_DW,
  parameter int unsigned AW = RAM_AW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do;

  modport slave (
    input  in_valid, in_data, out_ready, ram_do,
    output in_ready, out_valid, out_data, count, full, empty,
           ram_we, ram_di, ram_addr
  );

  modport master (
    output in_valid, in_data, out_ready, ram_do,
    input  in_ready, out_valid, out_data, count, full, empty,
           ram_we, ram_di, ram_addr
  );

endinterface

// File: rtl/ram_fifo_ctrl_wrap_ctr.sv
// wrap_ctr: AW-bit pointer that advances by one when inc is high and wraps
// naturally at 2**AW.
//   clk, rst : clock, asynchronous active-high reset (pointer clears to 0)
//   inc      : advance on this edge
//   ptr      : current pointer value
module wrap_ctr
  import ram_fifo_pkg::*;
#(
  parameter int unsigned AW = RAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a single-port RAM into a FIFO. Each cycle the RAM port
// is a write slot, a read slot or idle; contended cycles alternate. The head
// entry is presented from a one-entry output register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ram_fifo_ctrl_if.slave (in_*/out_* handshakes, count/full/empty,
//              ram_we/ram_di/ram_addr to the RAM, ram_do from the RAM)
// Optional feature: define RAM_FIFO_CTRL_BYPASS_EN to let a push into an
// empty queue load the output register directly (1-edge latency).
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned DW = RAM_DW,
  parameter int unsigned AW = RAM_AW
) (
  input logic            clk,
  input logic            rst,
  ram_fifo_ctrl_if.slave bus
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  grant_t        last_grant_q, last_grant_d;

  logic full, empty;
  logic wr_req, rd_req, byp;
  logic wr_gnt, rd_gnt;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Request, bypass and slot arbitration; next-state for all registers.
  always_comb begin
    byp          = 1'b0;
    wr_gnt       = 1'b0;
    rd_gnt       = 1'b0;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;

    wr_req = bus.in_valid && !full;
    rd_req = !empty && (!out_valid_q || bus.out_ready);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    byp = empty && (!out_valid_q || bus.out_ready) && bus.in_valid;
`endif

    // Bypass only fires when empty, so it never competes with a read.
    if (!byp) begin
      if (wr_req && rd_req) begin
        wr_gnt       = (last_grant_q == GRANT_READ);
        rd_gnt       = (last_grant_q == GRANT_WRITE);
        last_grant_d = (last_grant_q == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
      end else begin
        wr_gnt = wr_req;
        rd_gnt = rd_req;
      end
    end

    if (wr_gnt)      count_d = count_q + CW'(1);
    else if (rd_gnt) count_d = count_q - CW'(1);

    if (rd_gnt) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.ram_do;
    end else if (byp) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      last_grant_q <= GRANT_READ;
    end else begin
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  wrap_ctr #(.AW(AW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_gnt), .ptr(wr_ptr));
  wrap_ctr #(.AW(AW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_gnt), .ptr(rd_ptr));

  // in_ready mirrors the write grant without looking at in_valid.
  assign bus.in_ready  = !full && (!rd_req || last_grant_q == GRANT_READ);
  assign bus.ram_we    = wr_gnt;
  assign bus.ram_di    = bus.in_data;
  assign bus.ram_addr  = wr_gnt ? wr_ptr : rd_ptr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl with an 8x4 RAM
// model and a queue-based reference model of the FIFO behaviour.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  localparam int unsigned DW    = RAM_DW;
  localparam int unsigned AW    = RAM_AW;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = RAM_DEPTH;
`ifdef RAM_FIFO_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
  assign bus.ram_do = mem[bus.ram_addr];

  // Reference model: queue of stored entries plus the output register.
  logic [DW-1:0] mq[$];
  bit            m_ov;
  logic [DW-1:0] m_od;
  bit            m_last_rd;
  int unsigned   m_widx, m_ridx;
  bit            e_wr, e_rd, e_byp, e_in_ready, e_contend, e_ordy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0; m_od = '0; m_last_rd = 1'b1; m_widx = 0; m_ridx = 0;
  endtask

  task automatic model_decide();
    bit emp, ful, wreq, rreq;
    emp  = (mq.size() == 0);
    ful  = (mq.size() == DEPTH);
    wreq = bus.in_valid && !ful;
    rreq = !emp && (!m_ov || bus.out_ready);
    e_byp = BYP && emp && (!m_ov || bus.out_ready) && bus.in_valid;
    e_wr = 1'b0; e_rd = 1'b0;
    e_contend = wreq && rreq && !e_byp;
    if (!e_byp) begin
      if (e_contend) begin e_wr = m_last_rd; e_rd = !m_last_rd; end
      else begin e_wr = wreq; e_rd = rreq; end
    end
    e_in_ready = !ful && (!rreq || m_last_rd);
    e_addr = AW'(e_wr ? (m_widx % DEPTH) : (m_ridx % DEPTH));
    e_din  = bus.in_data;
    e_ordy = bus.out_ready;
  endtask

  task automatic model_commit();
    if (e_wr) begin mq.push_back(e_din); m_widx++; end
    if (e_rd) begin m_od = mq.pop_front(); m_ov = 1'b1; m_ridx++; end
    else if (e_byp) begin m_od = e_din; m_ov = 1'b1; end
    else if (m_ov && e_ordy) m_ov = 1'b0;
    if (e_contend) m_last_rd = e_rd;
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] d, input bit ordy);
    bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    model_decide();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 7;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    if (bus.count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
    if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", bus.full); end
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Put some state in, then reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(i + 3), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    tick();
    checks += 2;
    if (bus.out_valid !== m_ov) begin errors++; $display("FAIL pre_rst_out_valid: got %b want %b", bus.out_valid, m_ov); end
    if (bus.count !== CW'(mq.size())) begin errors++; $display("FAIL pre_rst_count: got %0d want %0d", bus.count, mq.size()); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.count !== '0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", bus.count); end
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL mid_rst_ram_we: got %b want 0", bus.ram_we); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 1", bus.in_ready); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %b want 1", bus.empty); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    int cyc;
    // Preload the output register so all following pushes land in RAM.
    drive(1'b1, DW'(15), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    cyc = 0;
    while (!bus.out_valid && cyc < 4) begin tick(); cyc++; end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(15)) begin
      errors++; $display("FAIL fill_preload: got v=%b d=%h want v=1 d=f", bus.out_valid, bus.out_data);
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      model_decide();
      checks += 3;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL fill_ram_we[%0d]: got %b want 1", i, bus.ram_we); end
      if (bus.ram_addr !== e_addr) begin errors++; $display("FAIL fill_ram_addr[%0d]: got %0d want %0d", i, bus.ram_addr, e_addr); end
      tick();
    end
    checks += 3;
    if (bus.count !== CW'(8)) begin errors++; $display("FAIL fill_count: got %0d want 8", bus.count); end
    if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready_full: got %b want 0", bus.in_ready); end
    drive(1'b1, DW'(9), 1'b0);
    checks++;
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL fill_9th_ram_we: got %b want 0", bus.ram_we); end
    tick();
    checks++;
    if (bus.count !== CW'(8)) begin errors++; $display("FAIL fill_9th_count: got %0d want 8", bus.count); end
  endtask

  task automatic test_drain();
    drive(1'b0, '0, 1'b1);
    checks += 2;
    if (bus.out_data !== DW'(15)) begin errors++; $display("FAIL drain_head: got %h want f", bus.out_data); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready_full: got %b want 0", bus.in_ready); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready_rise: got %b want 1", bus.in_ready); end
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      checks += 2;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", k, bus.out_valid); end
      if (bus.out_data !== DW'(k)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, bus.out_data, DW'(k)); end
    end
    tick();
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid: got %b want 0", bus.out_valid); end
    if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_end_empty: got %b want 1", bus.empty); end
    if (bus.count !== '0) begin errors++; $display("FAIL drain_end_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_wrap();
    int nxt_push, nxt_pop, cyc;
    do_reset();
    nxt_push = 1; nxt_pop = 1;
    for (int phase = 0; phase < 4; phase++) begin
      cyc = 0;
      // Phases: push to 8, pop to 5, push to 13, pop to 13.
      while (cyc < 60 && ((phase == 0 && nxt_push <= 8) || (phase == 1 && nxt_pop <= 5) ||
                          (phase == 2 && nxt_push <= 13) || (phase == 3 && nxt_pop <= 13))) begin
        if (phase == 0 || phase == 2) drive(1'b1, DW'(nxt_push), 1'b0);
        else drive(1'b0, '0, 1'b1);
        model_decide();
        checks += 2;
        if (bus.in_ready !== e_in_ready) begin errors++; $display("FAIL wrap_in_ready: got %b want %b", bus.in_ready, e_in_ready); end
        if (bus.ram_addr !== e_addr) begin errors++; $display("FAIL wrap_ram_addr: got %0d want %0d", bus.ram_addr, e_addr); end
        if (bus.in_valid && bus.in_ready) nxt_push++;
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (bus.out_data !== DW'(nxt_pop)) begin errors++; $display("FAIL wrap_pop: got %h want %h", bus.out_data, DW'(nxt_pop)); end
          nxt_pop++;
        end
        tick();
        cyc++;
      end
      checks++;
      if (cyc >= 60) begin errors++; $display("FAIL wrap_timeout: phase %0d push=%0d pop=%0d", phase, nxt_push, nxt_pop); end
    end
    drive(1'b0, '0, 1'b1);
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end_valid: got %b want 0", bus.out_valid); end
    if (bus.count !== '0) begin errors++; $display("FAIL wrap_end_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_contention();
    int nxt_push, nxt_pop, cyc;
    logic prev_we;
    do_reset();
    nxt_push = 1; nxt_pop = 1; cyc = 0;
    while (!(mq.size() == 4 && m_ov) && cyc < 20) begin
      drive(1'b1, DW'(nxt_push), 1'b0);
      if (bus.in_ready) nxt_push++;
      tick();
      cyc++;
    end
    checks++;
    if (bus.count !== CW'(4) || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL cont_setup: got count=%0d v=%b want count=4 v=1", bus.count, bus.out_valid);
    end
    prev_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(nxt_push), 1'b1);
      model_decide();
      checks++;
      if (bus.ram_we !== e_wr) begin errors++; $display("FAIL cont_grant[%0d]: got we=%b want %b", i, bus.ram_we, e_wr); end
      if (i > 0) begin
        checks++;
        if (bus.ram_we === prev_we) begin errors++; $display("FAIL cont_alternate[%0d]: got we=%b twice", i, bus.ram_we); end
      end
      prev_we = bus.ram_we;
      if (bus.in_ready) nxt_push++;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_data !== DW'(nxt_pop)) begin errors++; $display("FAIL cont_pop: got %h want %h", bus.out_data, DW'(nxt_pop)); end
        nxt_pop++;
      end
      tick();
      checks++;
      if ((bus.count !== CW'(4) && bus.count !== CW'(5)) || bus.count !== CW'(mq.size())) begin
        errors++; $display("FAIL cont_count[%0d]: got %0d want %0d (4 or 5)", i, bus.count, mq.size());
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    drive(1'b1, DW'(10), 1'b0);
    checks++;
    if (bus.ram_we !== !BYP) begin errors++; $display("FAIL lat_ram_we: got %b want %b", bus.ram_we, !BYP); end
    tick();
    drive(1'b0, '0, 1'b0);
    checks += 2;
    if (bus.out_valid !== BYP) begin errors++; $display("FAIL lat_edge1_valid: got %b want %b", bus.out_valid, BYP); end
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL lat_edge1_ram_we: got %b want 0", bus.ram_we); end
    tick();
    checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_edge2_valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== DW'(10)) begin errors++; $display("FAIL lat_edge2_data: got %h want a", bus.out_data); end
    if (bus.count !== '0) begin errors++; $display("FAIL lat_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_random();
    int pv, pr;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pv = ((c / 50) % 2 == 0) ? 80 : 30;
      pr = ((c / 50) % 2 == 0) ? 30 : 80;
      drive($urandom_range(99) < pv, DW'($urandom), $urandom_range(99) < pr);
      model_decide();
      checks += 4;
      if (bus.in_ready !== e_in_ready) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, bus.in_ready, e_in_ready); end
      if (bus.ram_we !== e_wr) begin errors++; $display("FAIL rnd_ram_we@%0d: got %b want %b", c, bus.ram_we, e_wr); end
      if (bus.ram_addr !== e_addr) begin errors++; $display("FAIL rnd_ram_addr@%0d: got %0d want %0d", c, bus.ram_addr, e_addr); end
      if (bus.ram_di !== bus.in_data) begin errors++; $display("FAIL rnd_ram_di@%0d: got %h want %h", c, bus.ram_di, bus.in_data); end
      tick();
      checks += 4;
      if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid@%0d: got %b want %b", c, bus.out_valid, m_ov); end
      if (m_ov && bus.out_data !== m_od) begin errors++; $display("FAIL rnd_out_data@%0d: got %h want %h", c, bus.out_data, m_od); end
      if (bus.count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, bus.count, mq.size()); end
      if (bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin
        errors++; $display("FAIL rnd_flags@%0d: got full=%b empty=%b want size %0d", c, bus.full, bus.empty, mq.size());
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_contention();
    test_latency();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
